display_scan_ctrl: RTL and testbench

Time-multiplexed scanner for a bank of common-anode 7-segment digits that share one segment bus.
- Holds a committed hex value.
- Rotates through the digits, decoding each nibble to active-low segments (bit order abcdefg, a = bit 6).
- Inserts a blanking gap between digits to prevent ghosting.
- Accepts new values through a load/ack handshake; updates are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/disp_pkg.sv | 35 +++
 rtl/seg7_hex_decode.sv | 35 +++
 rtl/display_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
//   - SEG_BLANK and the hex glyphs 0..F. Segments are active-low, bit order
//     abcdefg, with segment a in bit 6.
//   - Scan FSM state encoding.
//   - Width of the digit index (covers up to 8 digits).
package disp_pkg;

    localparam int DIGIT_IDX_W = 3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Ports:
//   nibble  in   4  hex digit 0..F
//   seg     out  7  segments abcdefg, active-low (a = bit 6)
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for common-anode 7-segment digits sharing one
// segment bus. Each digit slot is BLANK_CYCLES dark cycles (anti-ghosting)
// followed by REFRESH_DIV-BLANK_CYCLES lit cycles. New values are staged in a
// pending register and committed only at a frame boundary or while idle.
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks zero digits above the
// most significant nonzero digit (digit 0 is always shown).
//
// Ports:
//   iclk       in   1             system clock
//   irst       in   1             synchronous reset, active-high
//   iEnable    in   1             1 = scan, 0 = dark (registers retained)
//   iValue     in   4*NUM_DIGITS  hex value, nibble k -> digit k
//   iLoad      in   1             capture iValue into the pending register
//   oAck       out  1             one-cycle pulse when pending is committed
//   oAn        out  NUM_DIGITS    digit enables, active-low
//   oSeg       out  7             segments abcdefg, active-low
//   oDigitIdx  out  3             index of the current digit slot
//
// Load/ack handshake: iLoad is a fire-and-forget request with no back
// pressure; every iLoad is accepted in the cycle it is high and replaces any
// value still pending. oAck pulses once, the cycle after the pending value is
// committed, so several loads before a commit yield a single oAck.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    iEnable,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic                    iLoad,
    output logic                    oAck,
    output logic [NUM_DIGITS-1:0]   oAn,
    output logic [6:0]              oSeg,
    output logic [DIGIT_IDX_W-1:0]  oDigitIdx
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]       BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIGIT_IDX_W-1:0] IDX_LAST   = DIGIT_IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIGIT_IDX_W-1:0] idx_q, idx_d;
    logic                   commit;

    logic [VAL_W-1:0]       committed_q;
    logic [VAL_W-1:0]       pend_q;
    logic                   pend_flag_q;

    logic                   ack_q;
    logic [NUM_DIGITS-1:0]  an_q;
    logic [6:0]             seg_q;

    logic [3:0]             nibble;
    logic [6:0]             glyph;
    logic                   blank_digit;

    // ---------------- scan FSM: state, slot counter, digit index ----------
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // The slot counter runs 0..REFRESH_DIV-1 across the whole slot; BLANK
    // covers the first BLANK_CYCLES counts and SHOW the remainder.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        if (!iEnable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            commit  = (state_q == IDLE) && pend_flag_q;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    commit  = pend_flag_q;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        // Frame boundary: last digit's SHOW into digit 0's BLANK.
                        commit  = pend_flag_q && (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // ---------------- pending / committed value ---------------------------
    // A load coinciding with a commit lands in pending after the commit has
    // taken the old pending value, so the flag stays set for the new one.
    always_ff @(posedge iclk) begin
        if (irst) begin
            committed_q <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            if (iLoad) pend_q <= iValue;
            if (iLoad)       pend_flag_q <= 1'b1;
            else if (commit) pend_flag_q <= 1'b0;
            if (commit) committed_q <= pend_q;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Bit k set when nibble k and every nibble above it are zero (k >= 1).
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (v[4*k +: 4] == 4'h0);
            m[k]       = zero_above;
        end
        return m;
    endfunction

    logic [NUM_DIGITS-1:0] mask_q;

    always_ff @(posedge iclk) begin
        if (irst)        mask_q <= lz_mask(VAL_W'(0));
        else if (commit) mask_q <= lz_mask(pend_q);
    end
`endif

    // ---------------- digit select and decode -----------------------------
    always_comb begin
        nibble      = 4'h0;
        blank_digit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == DIGIT_IDX_W'(k)) begin
                nibble = committed_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_digit = mask_q[k];
`endif
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // ---------------- registered outputs ---------------------------------
    // Anodes and segments update together from the current state, one
    // cycle behind the FSM.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ack_q <= 1'b0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            ack_q <= commit;
            if (state_q == SHOW) begin
                an_q  <= ~(NUM_DIGITS'(1) << idx_q);
                seg_q <= blank_digit ? SEG_BLANK : glyph;
            end else begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign oAck      = ack_q;
    assign oAn       = an_q;
    assign oSeg      = seg_q;
    assign oDigitIdx = idx_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Stimulus pushes expected lit slots and expected oAck
// cycles into queues; a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct {
        logic [31:0] start;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [2:0]  idx;
        logic [31:0] len;
    } slot_t;

    logic          iclk;
    logic          irst;
    logic          iEnable;
    logic [15:0]   iValue;
    logic          iLoad;
    logic          oAck;
    logic [ND-1:0] oAn;
    logic [6:0]    oSeg;
    logic [2:0]    oDigitIdx;

    logic [31:0] ack_q[$];
    slot_t       slot_q[$];

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] cyc    = 0;
    logic        mon_en = 1'b0;
    logic        lit_active = 1'b0;
    logic [31:0] lit_len = 0;
    slot_t       cur;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .iEnable   (iEnable),
        .iValue    (iValue),
        .iLoad     (iLoad),
        .oAck      (oAck),
        .oAn       (oAn),
        .oSeg      (oSeg),
        .oDigitIdx (oDigitIdx)
    );

    // ---------------- clock / reset -----------------
    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    always @(posedge iclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- helpers -----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Glyph table transcribed from the decode list (active-low abcdefg).
    function automatic logic [6:0] exp_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic push_slot(input logic [31:0] start, input int k,
                             input logic [6:0] seg, input logic [31:0] len);
        slot_t s;
        s.start = start;
        s.an    = ~(4'b0001 << k);
        s.seg   = seg;
        s.idx   = 3'(k);
        s.len   = len;
        slot_q.push_back(s);
    endtask

    // Lit output of slot k of a frame starting at base appears at base+8k+3
    // (2 blank states, then one register stage) and lasts 6 cycles.
    task automatic push_frame(input logic [31:0] base, input logic [15:0] val);
        logic [3:0] nib;
        for (int k = 0; k < ND; k++) begin
            nib = val[4*k +: 4];
            push_slot(base + 32'(RD * k + BC + 1), k, exp_glyph(nib), 32'(RD - BC));
        end
    endtask

    // Load sampled by the posedge that makes cyc == edge_abs.
    task automatic load_at(input logic [31:0] edge_abs, input logic [15:0] val);
        while (cyc < edge_abs - 1) @(negedge iclk);
        iLoad  = 1'b1;
        iValue = val;
        @(negedge iclk);
        iLoad  = 1'b0;
    endtask

    // ---------------- monitor / scoreboard -----------------
    always @(negedge iclk) begin
        if (mon_en) begin
            if (oAck === 1'b1) begin
                if (ack_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ack_unexpected: oAck=1 at cycle %0d, expected no ack", cyc);
                end else begin
                    chk("ack_cycle", cyc, ack_q.pop_front());
                end
            end
            if (oAn !== 4'hF) begin
                if (!lit_active) begin
                    if (slot_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL lit_unexpected: oAn=%b oSeg=%b at cycle %0d, expected dark", oAn, oSeg, cyc);
                    end else begin
                        cur        = slot_q.pop_front();
                        lit_active = 1'b1;
                        lit_len    = 0;
                        chk("slot_start", cyc, cur.start);
                        chk("slot_idx", 32'(oDigitIdx), 32'(cur.idx));
                    end
                end
                if (lit_active) begin
                    lit_len = lit_len + 1;
                    chk("slot_an", 32'(oAn), 32'(cur.an));
                    chk("slot_seg", 32'(oSeg), 32'(cur.seg));
                end
            end else begin
                chk("dark_seg", 32'(oSeg), 32'h7F);
                if (lit_active) begin
                    chk("slot_len", lit_len, cur.len);
                    lit_active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus -----------------
    logic [31:0] en;
    logic [31:0] en2;

    initial begin
        irst    = 1'b1;
        iEnable = 1'b1;
        iLoad   = 1'b1;
        iValue  = 16'hABCD;

        // Reset dominates enable and load.
        repeat (3) begin
            @(negedge iclk);
            chk("rst_an", 32'(oAn), 32'hF);
            chk("rst_seg", 32'(oSeg), 32'h7F);
            chk("rst_ack", 32'(oAck), 32'h0);
            chk("rst_idx", 32'(oDigitIdx), 32'h0);
        end
        irst    = 1'b0;
        iEnable = 1'b0;
        iLoad   = 1'b0;
        mon_en  = 1'b1;
        repeat (6) @(negedge iclk);
        chk("idle_idx", 32'(oDigitIdx), 32'h0);

        // Load while idle: commits on the next (idle) cycle.
        ack_q.push_back(cyc + 2);
        iLoad  = 1'b1;
        iValue = 16'h12AF;
        @(negedge iclk);
        iLoad = 1'b0;
        repeat (3) @(negedge iclk);

        // Enable; E0 is the next posedge.
        en      = cyc + 1;
        iEnable = 1'b1;
        push_frame(en + 0,  16'h12AF);
        push_frame(en + 32, 16'h12AF);
        push_frame(en + 64, 16'h2222);
        push_frame(en + 96, 16'h3333);
        push_slot(en + 128 + 3,  0, 7'b1001100, 6);
        push_slot(en + 128 + 11, 1, 7'b1001100, 6);
        push_slot(en + 128 + 19, 2, 7'b1001100, 2);
        ack_q.push_back(en + 64);
        ack_q.push_back(en + 96);
        ack_q.push_back(en + 128);

        // Two loads inside frame 1: only the last commits, at E64.
        load_at(en + 37, 16'h1111);
        load_at(en + 40, 16'h2222);
        // Pending 3333, then a load exactly on the E96 commit edge.
        load_at(en + 70, 16'h3333);
        load_at(en + 96, 16'h4444);

        // Drop enable in digit 2's SHOW slot of frame 4 (sampled at E148).
        while (cyc < en + 147) @(negedge iclk);
        iEnable = 1'b0;
        @(negedge iclk);
        chk("disable_idx", 32'(oDigitIdx), 32'h0);

        // Load 0050 while dark; idle commit.
        while (cyc < en + 150) @(negedge iclk);
        ack_q.push_back(cyc + 2);
        iLoad  = 1'b1;
        iValue = 16'h0050;
        @(negedge iclk);
        iLoad = 1'b0;

        // Re-enable: restart at digit 0 with a full blank gap.
        while (cyc < en + 155) @(negedge iclk);
        en2     = cyc + 1;
        iEnable = 1'b1;
        push_slot(en2 + 3,  0, 7'b0000001, 6);
        push_slot(en2 + 11, 1, 7'b0100100, 6);
`ifdef LEADING_ZERO_BLANK_EN
        push_slot(en2 + 19, 2, 7'b1111111, 6);
        push_slot(en2 + 27, 3, 7'b1111111, 6);
`else
        push_slot(en2 + 19, 2, 7'b0000001, 6);
        push_slot(en2 + 27, 3, 7'b0000001, 6);
`endif
        while (cyc < en2 + 32) @(negedge iclk);
        iEnable = 1'b0;
        repeat (10) @(negedge iclk);

        chk("slots_left", 32'(slot_q.size()), 32'h0);
        chk("acks_left", 32'(ack_q.size()), 32'h0);
        chk("lit_at_end", 32'(lit_active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
